// File: rtl/piece_drop_ctrl.sv
// rtl/piece_drop_ctrl.sv - cursor, drop animation and board state for a 7x6 connect-four board
module piece_drop_ctrl (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  output logic [9:0]  PieceX,
  output logic [9:0]  PieceY,
  output logic        Player,
  output logic        Falling,
  output logic [41:0] Board_occ,
  output logic [41:0] Board_owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FALL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DROP  = 8'h16;

  localparam logic [9:0] COL0_X    = 10'd75;
  localparam logic [9:0] HOVER_Y   = 10'd75;
  localparam logic [9:0] ROW0_Y    = 10'd135;
  localparam logic [9:0] PITCH     = 10'd60;
  localparam logic [9:0] FALL_STEP = 10'd4;

  localparam logic [2:0] COL_LAST  = 3'd6;
  localparam logic [2:0] COL_HOME  = 3'd3;
  localparam logic [2:0] COL_FULL  = 3'd6;
  localparam logic [2:0] ROW_LAST  = 3'd5;

  state_t      state, state_n;
  logic [2:0]  col, col_n;
  logic [2:0]  target_row, target_row_n;
  logic [7:0]  prev_key;
  logic [2:0]  height   [7];
  logic [2:0]  height_n [7];

  logic [9:0]  piece_x_n, piece_y_n;
  logic        player_n, falling_n;
  logic [41:0] occ_n, owner_n;

  logic        press;
  logic [2:0]  cur_height;
  logic [9:0]  target_y;
  logic [9:0]  fall_y;
  logic [5:0]  cell_idx;

  // Edge-detected key press plus geometry helpers for the current cursor/target
  always_comb begin
    press      = (keycode != prev_key) && (keycode != KEY_NONE);
    cur_height = height[col];
    target_y   = ROW0_Y + PITCH * {7'd0, target_row};
    fall_y     = PieceY + FALL_STEP;
    cell_idx   = {3'd0, target_row} * 6'd7 + {3'd0, col};
  end

  // Next-state and next-output logic; every output is the register fed from here
  always_comb begin
    state_n      = state;
    col_n        = col;
    target_row_n = target_row;
    piece_x_n    = PieceX;
    piece_y_n    = PieceY;
    player_n     = Player;
    falling_n    = Falling;
    occ_n        = Board_occ;
    owner_n      = Board_owner;
    height_n     = height;

    case (state)
      IDLE: begin
        piece_y_n = HOVER_Y;
        falling_n = 1'b0;
        if (press) begin
          if (keycode == KEY_LEFT) begin
            if (col != 3'd0) col_n = col - 3'd1;
          end else if (keycode == KEY_RIGHT) begin
            if (col != COL_LAST) col_n = col + 3'd1;
          end else if (keycode == KEY_DROP) begin
            // A full column swallows the drop; a full board is just seven full columns
            if (cur_height < COL_FULL) begin
              target_row_n = ROW_LAST - cur_height;
              state_n      = FALL;
              falling_n    = 1'b1;
            end
          end
        end
        piece_x_n = COL0_X + PITCH * {7'd0, col_n};
      end

      FALL: begin
        // Keys are ignored here; prev_key still tracks so held keys do not retrigger later
        falling_n = 1'b1;
        piece_y_n = fall_y;
        if (fall_y == target_y) state_n = COMMIT;
      end

      COMMIT: begin
        // Occupied cells are never rewritten even if the height bookkeeping were off
        if (!Board_occ[cell_idx]) begin
          occ_n[cell_idx]   = 1'b1;
          owner_n[cell_idx] = Player;
        end
        height_n[col] = height[col] + 3'd1;
        player_n      = ~Player;
        piece_y_n     = HOVER_Y;
        falling_n     = 1'b0;
        state_n       = IDLE;
      end

      default: begin
        state_n   = IDLE;
        piece_y_n = HOVER_Y;
        falling_n = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any fall in progress with no board write
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      col         <= COL_HOME;
      target_row  <= ROW_LAST;
      prev_key    <= KEY_NONE;
      PieceX      <= COL0_X + PITCH * {7'd0, COL_HOME};
      PieceY      <= HOVER_Y;
      Player      <= 1'b0;
      Falling     <= 1'b0;
      Board_occ   <= '0;
      Board_owner <= '0;
      for (int i = 0; i < 7; i++) height[i] <= 3'd0;
    end else begin
      state       <= state_n;
      col         <= col_n;
      target_row  <= target_row_n;
      prev_key    <= keycode;
      PieceX      <= piece_x_n;
      PieceY      <= piece_y_n;
      Player      <= player_n;
      Falling     <= falling_n;
      Board_occ   <= occ_n;
      Board_owner <= owner_n;
      for (int i = 0; i < 7; i++) height[i] <= height_n[i];
    end
  end

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// tb/tb_piece_drop_ctrl.sv - scoreboard bench for piece_drop_ctrl
module tb_piece_drop_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b0;
  logic [7:0]  keycode   = 8'h00;
  logic [9:0]  PieceX;
  logic [9:0]  PieceY;
  logic        Player;
  logic        Falling;
  logic [41:0] Board_occ;
  logic [41:0] Board_owner;

  piece_drop_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .PieceX      (PieceX),
    .PieceY      (PieceY),
    .Player      (Player),
    .Falling     (Falling),
    .Board_occ   (Board_occ),
    .Board_owner (Board_owner)
  );

  always #5 frame_clk = ~frame_clk;

  localparam int K_X = 0, K_Y = 1, K_PLAYER = 2, K_FALL = 3, K_OCC = 4, K_OWN = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // Frame counter shared by stimulus (tagging) and monitor (matching)
  always @(posedge frame_clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int kind);
    case (kind)
      K_X:      return {54'd0, PieceX};
      K_Y:      return {54'd0, PieceY};
      K_PLAYER: return {63'd0, Player};
      K_FALL:   return {63'd0, Falling};
      K_OCC:    return {22'd0, Board_occ};
      default:  return {22'd0, Board_owner};
    endcase
  endfunction

  // Monitor: pops every expectation tagged for this frame and compares mid-cycle
  always @(negedge frame_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [63:0] a;
      e = sb.pop_front();
      a = actual(e.kind);
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: stale expectation from frame %0d seen at frame %0d", e.name, e.cyc, cyc);
      end else if (a !== e.val) begin
        errors++;
        $display("FAIL %s @frame %0d: got %0h, expected %0h", e.name, cyc, a, e.val);
      end
    end
  end

  task automatic expect_out(input string name, input int kind, input logic [63:0] val);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] k);
    keycode = k;
    tick();
    keycode = 8'h00;
    tick();
  endtask

  task automatic drop_and_wait(input int row);
    keycode = 8'h16;
    tick();
    keycode = 8'h00;
    repeat (15 + 15 * row + 1) tick();
  endtask

  task automatic expect_reset_state(input string tag);
    expect_out({tag, "_x"},      K_X,      64'd255);
    expect_out({tag, "_y"},      K_Y,      64'd75);
    expect_out({tag, "_player"}, K_PLAYER, 64'd0);
    expect_out({tag, "_falling"},K_FALL,   64'd0);
    expect_out({tag, "_occ"},    K_OCC,    64'd0);
    expect_out({tag, "_owner"},  K_OWN,    64'd0);
  endtask

  logic [63:0] occ_exp;
  logic [63:0] own_exp;

  initial begin
    // Reset state
    tick();
    tick();
    expect_reset_state("reset");
    Reset = 1'b1;
    tick();
    expect_out("first_edge_x", K_X, 64'd255);

    // Held left moves once, then pulses saturate at column 0
    keycode = 8'h04;
    tick();
    expect_out("left_once_x", K_X, 64'd195);
    repeat (9) tick();
    expect_out("left_held_x", K_X, 64'd195);
    keycode = 8'h00;
    tick();
    pulse(8'h04);
    expect_out("left_c1_x", K_X, 64'd135);
    pulse(8'h04);
    expect_out("left_c0_x", K_X, 64'd75);
    pulse(8'h04);
    expect_out("left_sat_x", K_X, 64'd75);

    // Right to column 3, right saturation checked later implicitly not needed here
    pulse(8'h07);
    pulse(8'h07);
    pulse(8'h07);
    expect_out("right_c3_x", K_X, 64'd255);

    // First drop in column 3: 90 fall frames then one commit frame
    keycode = 8'h16;
    tick();
    keycode = 8'h00;
    expect_out("drop1_falling", K_FALL, 64'd1);
    expect_out("drop1_y0",      K_Y,    64'd75);
    for (int n = 1; n <= 90; n++) begin
      tick();
      expect_out("drop1_y", K_Y, 64'(75 + 4 * n));
    end
    expect_out("drop1_commit_falling", K_FALL, 64'd1);
    expect_out("drop1_commit_occ",     K_OCC,  64'd0);
    tick();
    occ_exp = 64'd1 << 38;
    own_exp = 64'd0;
    expect_out("drop1_idle_falling", K_FALL,   64'd0);
    expect_out("drop1_idle_y",       K_Y,      64'd75);
    expect_out("drop1_player",       K_PLAYER, 64'd1);
    expect_out("drop1_occ",          K_OCC,    occ_exp);
    expect_out("drop1_owner",        K_OWN,    own_exp);

    // Second drop in column 3 with key activity during the fall; drop held past commit
    keycode = 8'h16;
    tick();
    keycode = 8'h00;
    expect_out("drop2_falling", K_FALL, 64'd1);
    for (int n = 1; n <= 75; n++) begin
      if (n == 10) keycode = 8'h04;
      if (n == 11) keycode = 8'h00;
      if (n == 20) keycode = 8'h07;
      if (n == 21) keycode = 8'h00;
      if (n == 30) keycode = 8'h16;
      tick();
      expect_out("drop2_y", K_Y, 64'(75 + 4 * n));
      if (n == 12 || n == 22) expect_out("drop2_x_keys", K_X, 64'd255);
    end
    expect_out("drop2_commit_falling", K_FALL, 64'd1);
    tick();
    occ_exp = occ_exp | (64'd1 << 31);
    own_exp = own_exp | (64'd1 << 31);
    expect_out("drop2_player", K_PLAYER, 64'd0);
    expect_out("drop2_occ",    K_OCC,    occ_exp);
    expect_out("drop2_owner",  K_OWN,    own_exp);
    expect_out("drop2_x",      K_X,      64'd255);
    repeat (3) tick();
    expect_out("drop_held_no_retrigger", K_FALL, 64'd0);
    expect_out("drop_held_y",            K_Y,    64'd75);
    keycode = 8'h00;
    tick();

    // Fill column 0 with alternating owners, then a seventh drop is ignored
    pulse(8'h04);
    pulse(8'h04);
    pulse(8'h04);
    expect_out("col0_x", K_X, 64'd75);
    for (int r = 5; r >= 0; r--) drop_and_wait(r);
    occ_exp = occ_exp | (64'd1 << 35) | (64'd1 << 28) | (64'd1 << 21) |
              (64'd1 << 14) | (64'd1 << 7) | 64'd1;
    own_exp = own_exp | (64'd1 << 28) | (64'd1 << 14) | 64'd1;
    expect_out("col0_full_occ",    K_OCC,    occ_exp);
    expect_out("col0_full_owner",  K_OWN,    own_exp);
    expect_out("col0_full_player", K_PLAYER, 64'd0);
    keycode = 8'h16;
    tick();
    keycode = 8'h00;
    expect_out("full_col_falling", K_FALL, 64'd0);
    expect_out("full_col_y",       K_Y,    64'd75);
    repeat (5) tick();
    expect_out("full_col_occ", K_OCC, occ_exp);

    // Reset at fall frame 40 aborts immediately with no later commit
    pulse(8'h07);
    expect_out("abort_col1_x", K_X, 64'd135);
    keycode = 8'h16;
    tick();
    keycode = 8'h00;
    repeat (40) tick();
    expect_out("abort_y40", K_Y, 64'd235);
    tick();
    Reset = 1'b0;
    expect_reset_state("abort_async");
    tick();
    tick();
    Reset = 1'b1;
    repeat (100) tick();
    expect_out("abort_no_commit_occ", K_OCC,  64'd0);
    expect_out("abort_idle_falling",  K_FALL, 64'd0);
    expect_out("abort_idle_y",        K_Y,    64'd75);

    tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #100000;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL watchdog: got timeout at frame %0d, expected completion", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule

// File: doc/piece_drop_ctrl.md
PIECE_DROP_CTRL -- requirements
Module: piece_drop_ctrl

Interface
REQ-001 SHALL have port: frame_clk  input  1  sole clock; all state advances on its rising edge, one step per video frame.
REQ-002 SHALL have port: Reset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: keycode  input  8  current USB HID keycode; 0x04 = left, 0x07 = right, 0x16 = drop, others ignored.
REQ-004 SHALL have port: PieceX  output  10  screen X of the active piece sprite.
REQ-005 SHALL have port: PieceY  output  10  screen Y of the active piece sprite.
REQ-006 SHALL have port: Player  output  1  owner of the active piece; 0 = red, 1 = yellow.
REQ-007 SHALL have port: Falling  output  1  high while the drop animation is in progress (FALL or COMMIT).
REQ-008 SHALL have port: Board_occ  output  42  cell occupied flags; index = row*7 + col, row 0 = top, col 0 = left.
REQ-009 SHALL have port: Board_owner  output  42  cell owner (Player value at commit); meaningful only where Board_occ = 1.

Function
REQ-010 SHALL keep a cursor column col (0..6) and drive PieceX = 75 + 60*col.
REQ-011 SHALL use these geometry constants: hover Y = 75; cell (row r) Y = 135 + 60*r.
REQ-012 SHALL register keycode every frame as prev_key; a "press" is keycode != prev_key and keycode != 0x00.
REQ-013 SHALL implement states IDLE, FALL, COMMIT, held in a state register.
REQ-014 IDLE: PieceY SHALL equal 75, and Falling SHALL be 0.
REQ-015 IDLE, left press: col SHALL decrement, saturating at 0 with no wrap.
REQ-016 IDLE, right press: col SHALL increment, saturating at 6 with no wrap.
REQ-017 IDLE, drop press: if height[col] < 6, SHALL latch target_row = 5 - height[col] and enter FALL.
REQ-018 IDLE, drop press on a full column (height = 6): SHALL be ignored, with no state change.
REQ-019 SHALL keep a 3-bit height counter per column, range 0..6.
REQ-020 FALL: PieceY SHALL increase by 4 each frame.
REQ-021 FALL: on the frame PieceY reaches 135 + 60*target_row (exact, always a multiple of 4 from 75), SHALL enter COMMIT next edge.
REQ-022 FALL and COMMIT: keycode presses SHALL be ignored; prev_key SHALL still update, so a key held through the fall does not retrigger.
REQ-023 COMMIT, one frame, on exit edge: SHALL set Board_occ[target_row*7+col] = 1 and Board_owner[...] = Player.
REQ-024 COMMIT exit edge: SHALL increment height[col], toggle Player, set PieceY = 75, and return to IDLE; col SHALL be unchanged.
REQ-025 Fall latency from drop press into empty column: SHALL be 90 frames in FALL (75 -> 435) plus 1 COMMIT frame.
REQ-026 Board bits SHALL never be cleared except by reset.
REQ-027 A committed cell SHALL never be rewritten.
REQ-028 When all 42 cells are full, all drop presses SHALL be ignored; left/right SHALL still move the cursor.
REQ-029 All outputs SHALL be registered, with no combinational path from keycode to outputs.

Reset
REQ-030 Reset low SHALL immediately, asynchronously, force: state = IDLE, col = 3, PieceX = 255, PieceY = 75, Player = 0, Falling = 0.
REQ-031 Reset low SHALL also force: all heights = 0, Board_occ = 0, Board_owner = 0, prev_key = 0x00.
REQ-032 Reset asserted mid-FALL or mid-COMMIT SHALL abort with no board write.
REQ-033 After reset release, the first frame edge SHALL operate from IDLE.

Verification
REQ-034 Reset, then keycode 0x04 held 10 frames -> col = 2 (single move), PieceX = 195; release then 3 more left presses -> col = 0, PieceX = 75 (saturates).
REQ-035 Drop on col 3 after reset -> Falling = 1 next frame, PieceY 75 -> 435 in steps of 4, COMMIT -> Board_occ[38] = 1, Board_owner[38] = 0, Player = 1, PieceY = 75.
REQ-036 Six drops in col 0, alternating players -> Board_occ bits 35, 28, 21, 14, 7, 0 set, owners 0,1,0,1,0,1; seventh drop press ignored, state stays IDLE.
REQ-037 Left/right/drop pulses during FALL -> col, board and timing unchanged vs. no-key run.
REQ-038 Reset asserted at FALL frame 40 -> all outputs at reset values, Board_occ = 0 immediately, no commit afterward.
